// File: rtl/dmem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the M-stage data-memory access unit:
//   - state_e      : access FSM states
//   - SZ_*         : MemSizeM (funct3) encodings
//   - LANES        : byte lanes on the 32-bit data bus
//   - is_misaligned: illegal size / alignment check for an incoming request
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int LANES = 4;

  // Unsigned sizes exist only for loads, so a BU/HU store is illegal.
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [1:0] addr_lo,
                                         input logic       we);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo;
      SZ_BU:   bad = we;
      SZ_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
// Data-memory bus with request/grant/response handshake.
//   master (access unit): drives DReq, DWe, DAddr, DBe, DWData;
//                         receives DGnt, DRValid, DRData
//   slave  (memory)     : the reverse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface dmem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  DReq;
  logic                  DWe;
  logic [ADDR_WIDTH-1:0] DAddr;
  logic [3:0]            DBe;
  logic [DATA_WIDTH-1:0] DWData;
  logic                  DGnt;
  logic                  DRValid;
  logic [DATA_WIDTH-1:0] DRData;

  modport master (
    output DReq, DWe, DAddr, DBe, DWData,
    input  DGnt, DRValid, DRData
  );

  modport slave (
    input  DReq, DWe, DAddr, DBe, DWData,
    output DGnt, DRValid, DRData
  );
endinterface

// File: rtl/dmem_access_unit_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align (combinational)
// Request side : byte enables and lane-replicated store data from the
//                incoming size / low address bits.
// Response side: right-aligns the addressed byte/halfword of the read word
//                and zeroes the upper bits (extension happens downstream).
// Ports:
//   req_sz, req_lo, req_wdata -> req_be, req_wdata_rep
//   rsp_sz, rsp_lo, rsp_rdata -> rsp_rdata_al
// Only size[1:0] matters here: BU/HU share lane handling with B/H.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_lane_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            req_sz,
  input  logic [1:0]            req_lo,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [3:0]            req_be,
  output logic [DATA_WIDTH-1:0] req_wdata_rep,
  input  logic [1:0]            rsp_sz,
  input  logic [1:0]            rsp_lo,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] rsp_rdata_al
);

  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;

  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_sz)
      2'b00: begin
        req_be        = 4'b0001 << req_lo;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << {req_lo[1], 1'b0};
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_shift   = rsp_rdata >> {rsp_lo, 3'b000};
    half_shift   = rsp_rdata >> {rsp_lo[1], 4'b0000};
    rsp_rdata_al = rsp_rdata;
    case (rsp_sz)
      2'b00:   rsp_rdata_al = {{(DATA_WIDTH-8){1'b0}}, byte_shift[7:0]};
      2'b01:   rsp_rdata_al = {{(DATA_WIDTH-16){1'b0}}, half_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
// M-stage data-memory access unit. Accepts one load/store from the pipeline,
// runs a single request/grant/response transaction on the data bus, stalls
// the pipeline while it is in flight and returns right-aligned load data.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   MemReqM..        : M-stage request (MemReqM, MemWriteM, MemSizeM, FlushM,
//                      ALUResultM, WriteDataM)
//   ReadDataM        : aligned load data, held until the next load capture
//   StallM           : hold F/D/E/M
//   MisalignM        : illegal size/alignment, request dropped (IDLE only)
//   bus              : data-memory bus (master side)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReqM,
  input  logic                  MemWriteM,
  input  logic [2:0]            MemSizeM,
  input  logic                  FlushM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  dmem_access_unit_if.master    bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [3:0]            req_be;
  logic [DATA_WIDTH-1:0] req_wdata_rep;
  logic [DATA_WIDTH-1:0] rsp_rdata_al;
  logic                  req_live;
  logic                  req_bad;

  // Request-side lanes come from the live M-stage inputs (captured on accept);
  // response-side alignment uses the registered size/address of the access.
  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .req_sz        (MemSizeM[1:0]),
    .req_lo        (ALUResultM[1:0]),
    .req_wdata     (WriteDataM),
    .req_be        (req_be),
    .req_wdata_rep (req_wdata_rep),
    .rsp_sz        (size_q),
    .rsp_lo        (addr_q[1:0]),
    .rsp_rdata     (bus.DRData),
    .rsp_rdata_al  (rsp_rdata_al)
  );

  assign req_live = MemReqM && !FlushM;
  assign req_bad  = is_misaligned(MemSizeM, ALUResultM[1:0], MemWriteM);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_live) begin
          MisalignM = req_bad;
          if (!req_bad) begin
            addr_d  = ALUResultM;
            we_d    = MemWriteM;
            be_d    = req_be;
            wdata_d = req_wdata_rep;
            size_d  = MemSizeM[1:0];
            StallM  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        StallM = 1'b1;
        if (bus.DGnt) state_d = we_q ? S_DONE : S_RESP;
      end
      S_RESP: begin
        StallM = 1'b1;
        if (bus.DRValid) begin
          rdata_d = rsp_rdata_al;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  // DReq decodes straight from the state flop, so it drops with the reset.
  assign bus.DReq   = (state_q == S_REQ);
  assign bus.DWe    = we_q;
  assign bus.DAddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.DBe    = be_q;
  assign bus.DWData = wdata_q;
  assign ReadDataM  = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
`timescale 1ns/1ps
module tb_dmem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        MemReqM;
  logic        MemWriteM;
  logic [2:0]  MemSizeM;
  logic        FlushM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;

  int total;
  int bad;

  dmem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif ();

  dmem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .MemSizeM   (MemSizeM),
    .FlushM     (FlushM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .bus        (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] dwd;
    int          stall;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int gd, input logic mis,
                              input logic [3:0] be, input logic [31:0] dwd,
                              input int st, input logic [31:0] er);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.gd = gd; v.mis = mis; v.be = be; v.dwd = dwd; v.stall = st; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  stall;
    int  dreq;
    bit  gnt_done;
    bit  rv_done;
    bit  done;
    @(posedge clk); #1;
    MemReqM = 1'b1; MemWriteM = v.we; MemSizeM = v.size;
    ALUResultM = v.addr; WriteDataM = v.wdata; bif.DRData = v.rdata;
    #1;
    chk({v.name, " misalign"}, {31'b0, MisalignM}, {31'b0, v.mis});
    if (v.mis) begin
      chk({v.name, " stall"}, {31'b0, StallM}, 32'd0);
      dreq = 0;
      repeat (3) begin
        @(posedge clk); #2;
        if (bif.DReq) dreq++;
      end
      MemReqM = 1'b0;
      chk({v.name, " dreq cycles"}, dreq, 32'd0);
      chk({v.name, " rdata"}, ReadDataM, v.exp_rd);
    end else begin
      stall = 0; dreq = 0; gnt_done = 0; rv_done = 0; done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
        if (k > 0) begin @(posedge clk); #2; end
        bif.DGnt = 1'b0; bif.DRValid = 1'b0;
        if (k > 0 && !StallM) begin
          done = 1;
        end else begin
          if (StallM) stall++;
          if (gnt_done && !v.we && !rv_done) begin
            bif.DRValid = 1'b1; rv_done = 1;
          end
          if (bif.DReq) begin
            dreq++;
            if (dreq == 1) begin
              chk({v.name, " DAddr"}, bif.DAddr, v.addr & 32'hFFFF_FFFC);
              chk({v.name, " DBe"}, {28'b0, bif.DBe}, {28'b0, v.be});
              chk({v.name, " DWe"}, {31'b0, bif.DWe}, {31'b0, v.we});
              if (v.we) chk({v.name, " DWData"}, bif.DWData, v.dwd);
            end
            if (dreq == v.gd + 1) begin
              bif.DGnt = 1'b1; gnt_done = 1;
            end
          end
        end
      end
      MemReqM = 1'b0;
      if (!done) chk({v.name, " timeout"}, 32'd1, 32'd0);
      chk({v.name, " stall cycles"}, stall, v.stall);
      chk({v.name, " dreq cycles"}, dreq, v.gd + 1);
      chk({v.name, " rdata"}, ReadDataM, v.exp_rd);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; MemReqM = 0; MemWriteM = 0; MemSizeM = 3'b010; FlushM = 0;
    ALUResultM = 0; WriteDataM = 0;
    bif.DGnt = 0; bif.DRValid = 0; bif.DRData = 0;

    //                name      we sz      addr          wdata         rdata         gd mis be       dwd           st exp_rd
    vt[0]  = mk("LW100",  0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        3, 32'hDEADBEEF);
    vt[1]  = mk("LB103",  0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 0, 4'b1000, 32'h0,        3, 32'h00000080);
    vt[2]  = mk("LHU102", 0, 3'b101, 32'h102, 32'h0,        32'h80112233, 0, 0, 4'b1100, 32'h0,        3, 32'h00008011);
    vt[3]  = mk("SB201",  1, 3'b000, 32'h201, 32'h000000AB, 32'h0,        3, 0, 4'b0010, 32'hABABABAB, 5, 32'h00008011);
    vt[4]  = mk("LH101",  0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        0, 32'h00008011);
    vt[5]  = mk("SW102",  1, 3'b010, 32'h102, 32'h12345678, 32'h0,        0, 1, 4'b0000, 32'h0,        0, 32'h00008011);
    vt[6]  = mk("LBU101", 0, 3'b100, 32'h101, 32'h0,        32'h80112233, 1, 0, 4'b0010, 32'h0,        4, 32'h00000022);
    vt[7]  = mk("SH206",  1, 3'b001, 32'h206, 32'h1234CAFE, 32'h0,        0, 0, 4'b1100, 32'hCAFECAFE, 2, 32'h00000022);
    vt[8]  = mk("LH100",  0, 3'b001, 32'h100, 32'h0,        32'h80112233, 2, 0, 4'b0011, 32'h0,        5, 32'h00002233);
    vt[9]  = mk("SZ011",  0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        0, 32'h00002233);
    vt[10] = mk("SBU",    1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        0, 32'h00002233);
    vt[11] = mk("SW300",  1, 3'b010, 32'h300, 32'h12345678, 32'h0,        0, 0, 4'b1111, 32'h12345678, 2, 32'h00002233);
    vt[12] = mk("LW300",  0, 3'b010, 32'h300, 32'h0,        32'h12345678, 0, 0, 4'b1111, 32'h0,        3, 32'h12345678);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst DReq", {31'b0, bif.DReq}, 32'd0);
    chk("rst DWe", {31'b0, bif.DWe}, 32'd0);
    chk("rst DAddr", bif.DAddr, 32'd0);
    chk("rst DBe", {28'b0, bif.DBe}, 32'd0);
    chk("rst DWData", bif.DWData, 32'd0);
    chk("rst ReadDataM", ReadDataM, 32'd0);
    chk("rst StallM", {31'b0, StallM}, 32'd0);
    chk("rst MisalignM", {31'b0, MisalignM}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vt[i]);

    // Flush in IDLE: request dropped
    @(posedge clk); #1;
    MemReqM = 1; MemWriteM = 0; MemSizeM = 3'b010; ALUResultM = 32'h104; FlushM = 1;
    #1;
    chk("flushidle StallM", {31'b0, StallM}, 32'd0);
    chk("flushidle MisalignM", {31'b0, MisalignM}, 32'd0);
    @(posedge clk); #2;
    chk("flushidle DReq", {31'b0, bif.DReq}, 32'd0);
    MemReqM = 0; FlushM = 0;

    // Stray grant in IDLE ignored
    bif.DGnt = 1;
    @(posedge clk); #2;
    bif.DGnt = 0;
    chk("straygnt DReq", {31'b0, bif.DReq}, 32'd0);
    chk("straygnt StallM", {31'b0, StallM}, 32'd0);

    // Flush during RESP: transaction still completes
    @(posedge clk); #1;
    MemReqM = 1; MemWriteM = 0; MemSizeM = 3'b010; ALUResultM = 32'h104;
    #1;
    chk("flushresp accept stall", {31'b0, StallM}, 32'd1);
    @(posedge clk); #2;
    chk("flushresp DReq", {31'b0, bif.DReq}, 32'd1);
    bif.DGnt = 1; bif.DRValid = 1; bif.DRData = 32'h11111111;
    @(posedge clk); #2;
    bif.DGnt = 0; bif.DRValid = 0; FlushM = 1;
    chk("flushresp resp stall", {31'b0, StallM}, 32'd1);
    chk("flushresp resp DReq", {31'b0, bif.DReq}, 32'd0);
    @(posedge clk); #2;
    chk("flushresp still stall", {31'b0, StallM}, 32'd1);
    bif.DRValid = 1; bif.DRData = 32'h0BADF00D;
    @(posedge clk); #2;
    bif.DRValid = 0;
    chk("flushresp done stall", {31'b0, StallM}, 32'd0);
    chk("flushresp rdata", ReadDataM, 32'h0BADF00D);
    MemReqM = 0; FlushM = 0;

    // Reset during RESP
    @(posedge clk); #1;
    MemReqM = 1; MemWriteM = 0; MemSizeM = 3'b010; ALUResultM = 32'h108;
    @(posedge clk); #2;
    bif.DGnt = 1;
    @(posedge clk); #2;
    bif.DGnt = 0;
    chk("rstresp pre stall", {31'b0, StallM}, 32'd1);
    #1; rst_n = 0; MemReqM = 0;
    #1;
    chk("rstresp DReq", {31'b0, bif.DReq}, 32'd0);
    chk("rstresp StallM", {31'b0, StallM}, 32'd0);
    chk("rstresp ReadDataM", ReadDataM, 32'd0);
    @(negedge clk); rst_n = 1;
    bif.DRValid = 1; bif.DRData = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #2;
    bif.DRValid = 0;
    chk("stray rvalid ReadDataM", ReadDataM, 32'd0);
    chk("stray rvalid StallM", {31'b0, StallM}, 32'd0);
    chk("stray rvalid DReq", {31'b0, bif.DReq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
